// File: rtl/register_file_pkg.sv
// Shared definitions for the register file and the ALU it feeds.
// Contents:
//   RF_WIDTH / RF_ADDR_W : default data and address widths
//   REG_ZERO             : the hard-wired zero register address
//   RF_RESET_VAL         : value every entry takes on reset
//   alu_op_e             : ALU op-codes (shared with the ALU)
//   is_reg_zero          : helper that flags the zero register address
package register_file_pkg;

    localparam int RF_WIDTH  = 32;
    localparam int RF_ADDR_W = 5;

    localparam logic [RF_ADDR_W-1:0] REG_ZERO     = 5'd0;
    localparam logic [RF_WIDTH-1:0]  RF_RESET_VAL = 32'h0000_0000;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_op_e;

    function automatic logic is_reg_zero(input logic [RF_ADDR_W-1:0] addr);
        return (addr == REG_ZERO);
    endfunction

endpackage

// File: rtl/register_file_if.sv
// Register file access bus: two read ports and one write port.
// Modports:
//   master : drives addresses and write data, receives read data (ALU side)
//   slave  : the register file itself
interface register_file_if
    import register_file_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH,
    parameter int ADDR_W = RF_ADDR_W
) ();

    logic [ADDR_W-1:0] rd_addr0;
    logic [ADDR_W-1:0] rd_addr1;
    logic [WIDTH-1:0]  rd_data0;
    logic [WIDTH-1:0]  rd_data1;
    logic              wr_ena;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    modport master (
        output rd_addr0, rd_addr1, wr_ena, wr_addr, wr_data,
        input  rd_data0, rd_data1
    );

    modport slave (
        input  rd_addr0, rd_addr1, wr_ena, wr_addr, wr_data,
        output rd_data0, rd_data1
    );

endinterface

// File: rtl/register_file_decoder_5_to_32.sv
// Write address decoder: turns wr_addr into one-hot per-entry write enables.
// Ports:
//   ena    : write enable; all outputs low when 0
//   addr   : write address
//   onehot : one bit per entry; bit 0 is tied low so the zero register
//            can never be written
module decoder_5_to_32
    import register_file_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic                   ena,
    input  logic [ADDR_W-1:0]      addr,
    output logic [(2**ADDR_W)-1:0] onehot
);

    localparam int DEPTH = 2**ADDR_W;

    // One-hot decode of the write address, gated by the enable
    always_comb begin
        onehot = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (ena && (addr == ADDR_W'(i))) begin
                onehot[i] = 1'b1;
            end else begin
                onehot[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/register_file.sv
// Two-read / one-write register file supplying ALU operands X and Y and
// accepting the ALU result Z for writeback.
// Ports:
//   clk  : rising-edge clock
//   rstb : synchronous active-low reset; clears storage and forces reads to 0
//   bus  : register_file_if slave (rd_addr0/1, rd_data0/1, wr_ena/addr/data)
// Reads are combinational with a write-first bypass, so a read of the
// address being written returns the incoming data in the same cycle.
// Entry 0 has no storage and always reads zero.
module register_file
    import register_file_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic            clk,
    input  logic            rstb,
    register_file_if.slave  bus
);

    localparam int DEPTH = 2**ADDR_W;

    logic [WIDTH-1:0] mem_r [1:DEPTH-1];
    logic [DEPTH-1:0] wr_sel_s;
    logic [WIDTH-1:0] mux0_s;
    logic [WIDTH-1:0] mux1_s;
    logic             hit0_s;
    logic             hit1_s;
    logic [WIDTH-1:0] rd0_s;
    logic [WIDTH-1:0] rd1_s;

    decoder_5_to_32 #(
        .ADDR_W (ADDR_W)
    ) u_wr_dec (
        .ena    (bus.wr_ena),
        .addr   (bus.wr_addr),
        .onehot (wr_sel_s)
    );

    // Storage array: reset clears every entry and takes priority over writes
    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int i = 1; i < DEPTH; i++) begin
                mem_r[i] <= WIDTH'(RF_RESET_VAL);
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_sel_s[i]) begin
                    mem_r[i] <= bus.wr_data;
                end else begin
                    mem_r[i] <= mem_r[i];
                end
            end
        end
    end

    // Storage read muxes; address 0 falls through to the zero default
    always_comb begin
        mux0_s = WIDTH'(RF_RESET_VAL);
        mux1_s = WIDTH'(RF_RESET_VAL);
        for (int i = 1; i < DEPTH; i++) begin
            mux0_s = (bus.rd_addr0 == ADDR_W'(i)) ? mem_r[i] : mux0_s;
            mux1_s = (bus.rd_addr1 == ADDR_W'(i)) ? mem_r[i] : mux1_s;
        end
    end

    // Bypass comparators; the zero register never bypasses
    always_comb begin
        hit0_s = bus.wr_ena && (bus.wr_addr == bus.rd_addr0) &&
                 (bus.rd_addr0 != ADDR_W'(REG_ZERO));
        hit1_s = bus.wr_ena && (bus.wr_addr == bus.rd_addr1) &&
                 (bus.rd_addr1 != ADDR_W'(REG_ZERO));
    end

    // Output select: reset forces zero and overrides the bypass
    always_comb begin
        if (!rstb) begin
            rd0_s = WIDTH'(RF_RESET_VAL);
            rd1_s = WIDTH'(RF_RESET_VAL);
        end else begin
            rd0_s = hit0_s ? bus.wr_data : mux0_s;
            rd1_s = hit1_s ? bus.wr_data : mux1_s;
        end
    end

    assign bus.rd_data0 = rd0_s;
    assign bus.rd_data1 = rd1_s;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file. Expected read data is queued when
// stimulus is applied and compared against the ports on the falling edge.
module tb_register_file;
    import register_file_pkg::*;

    logic clk = 1'b0;
    logic rstb;

    always #5 clk = ~clk;

    register_file_if #(.WIDTH(RF_WIDTH), .ADDR_W(RF_ADDR_W)) bus ();

    register_file #(
        .WIDTH  (RF_WIDTH),
        .ADDR_W (RF_ADDR_W)
    ) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_data_q [$];
    int          exp_port_q [$];
    string       exp_tag_q  [$];

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic expect_port(input int port, input logic [31:0] data,
                               input string tag);
        exp_port_q.push_back(port);
        exp_data_q.push_back(data);
        exp_tag_q.push_back(tag);
    endtask

    task automatic drain();
        logic [31:0] exp;
        logic [31:0] obs;
        int          port;
        string       tag;
        while (exp_data_q.size() > 0) begin
            exp  = exp_data_q.pop_front();
            port = exp_port_q.pop_front();
            tag  = exp_tag_q.pop_front();
            obs  = (port == 0) ? bus.rd_data0 : bus.rd_data1;
            check_value(tag, obs, exp);
        end
    endtask

    // Compare queued expectations mid-cycle, then advance past the next edge
    task automatic step();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ena, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] ra0,
                         input logic [4:0] ra1);
        bus.wr_ena   = ena;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.rd_addr0 = ra0;
        bus.rd_addr1 = ra1;
    endtask

    function automatic logic [31:0] alu_eval(input alu_op_e op,
                                             input logic [31:0] x,
                                             input logic [31:0] y,
                                             output logic ovf);
        logic [31:0] z;
        ovf = 1'b0;
        case (op)
            ALU_ADD: begin
                z   = x + y;
                ovf = (x[31] == y[31]) && (z[31] != x[31]);
            end
            ALU_SUB: begin
                z   = x - y;
                ovf = (x[31] != y[31]) && (z[31] != x[31]);
            end
            ALU_AND: z = x & y;
            ALU_OR:  z = x | y;
            ALU_XOR: z = x ^ y;
            default: z = 32'h0000_0000;
        endcase
        return z;
    endfunction

    logic [31:0] z;
    logic        ovf;
    logic [31:0] val;

    initial begin
        rstb = 1'b0;
        drive(1'b1, 5'd5, 32'h5555_AAAA, 5'd5, 5'd0);
        expect_port(0, 32'h0, "rst_force_p0");
        expect_port(1, 32'h0, "rst_force_p1");
        step();
        step();

        rstb = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
        expect_port(0, 32'h0, "post_rst_r5");
        expect_port(1, 32'h0, "post_rst_r31");
        step();

        // Reset clear: write r5, then reset with a write pending to r3
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0);
        expect_port(0, 32'hDEAD_BEEF, "byp_r5");
        expect_port(1, 32'h0, "r0_during_wr");
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        expect_port(0, 32'hDEAD_BEEF, "stored_r5_p0");
        expect_port(1, 32'hDEAD_BEEF, "stored_r5_p1");
        step();
        rstb = 1'b0;
        drive(1'b1, 5'd3, 32'h1234_5678, 5'd3, 5'd5);
        expect_port(0, 32'h0, "rst_no_byp");
        expect_port(1, 32'h0, "rst_force_r5");
        step();
        rstb = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        expect_port(0, 32'h0, "clr_r3_p0");
        expect_port(1, 32'h0, "clr_r3_p1");
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        expect_port(0, 32'h0, "clr_r5_p0");
        expect_port(1, 32'h0, "clr_r5_p1");
        step();

        // Write/readback of every entry
        for (int n = 1; n < 32; n++) begin
            val = 32'(n) * 32'h0101_0101;
            drive(1'b1, 5'(n), val, 5'd0, 5'd0);
            step();
        end
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
            expect_port(0, 32'(a) * 32'h0101_0101, "sweep_p0");
            expect_port(1, 32'(31 - a) * 32'h0101_0101, "sweep_p1");
            step();
        end

        // Zero register ignores writes and never bypasses
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        expect_port(0, 32'h0, "r0_wr_p0");
        expect_port(1, 32'h0, "r0_wr_p1");
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        expect_port(0, 32'h0, "r0_after_p0");
        expect_port(1, 32'h0, "r0_after_p1");
        step();

        // Bypass on one port while the other reads storage
        drive(1'b1, 5'd7, 32'h0000_0011, 5'd0, 5'd0);
        step();
        drive(1'b1, 5'd7, 32'h0000_0022, 5'd7, 5'd8);
        expect_port(0, 32'h0000_0022, "byp_r7");
        expect_port(1, 32'h0808_0808, "nobyp_r8");
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        expect_port(0, 32'h0000_0022, "r7_commit_p0");
        expect_port(1, 32'h0000_0022, "r7_commit_p1");
        step();

        // ALU loop: r3 <= r1 + r2
        drive(1'b1, 5'd1, 32'h7FFF_FFFF, 5'd0, 5'd0);
        step();
        drive(1'b1, 5'd2, 32'h0000_0001, 5'd0, 5'd0);
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        #1;
        z = alu_eval(ALU_ADD, bus.rd_data0, bus.rd_data1, ovf);
        check_value("alu_ovf", {31'b0, ovf}, 32'h0000_0001);
        bus.wr_ena  = 1'b1;
        bus.wr_addr = 5'd3;
        bus.wr_data = z;
        expect_port(0, 32'h7FFF_FFFF, "alu_x");
        expect_port(1, 32'h0000_0001, "alu_y");
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        expect_port(0, 32'h8000_0000, "alu_z_p0");
        expect_port(1, 32'h8000_0000, "alu_z_p1");
        step();

        // wr_ena low: no write and no bypass
        drive(1'b1, 5'd9, 32'h0000_0009, 5'd0, 5'd0);
        step();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 5'd9, 32'hAAAA_AAAA, 5'd9, 5'd9);
            expect_port(0, 32'h0000_0009, "hold_p0");
            expect_port(1, 32'h0000_0009, "hold_p1");
            step();
        end
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        expect_port(0, 32'h0000_0009, "hold_after");
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
